// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-tick divider, h/v counters and registered sync/video decode.
// Optional macro VGA_SYNC_FRAME_CNT_EN adds an 8-bit wrapping frame counter output.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  // Decode limits are 11 bits wide so a 1024-count raster cannot alias to zero.
  localparam logic [10:0]   H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0]   HS_BEG   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0]   HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0]   V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0]   VS_BEG   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0]   VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DW-1:0] div_cnt_r;
  logic [DW-1:0] div_next_s;
  logic          tick_s;
  logic          h_wrap_s;
  logic          frame_wrap_s;
  logic [9:0]    h_r;
  logic [9:0]    v_r;
  logic [9:0]    h_next_s;
  logic [9:0]    v_next_s;
  logic          p_tick_r;
  logic          video_on_r;
  logic          hsync_r;
  logic          vsync_r;
  logic          frame_start_r;

  // Next-state computation for divider and raster counters.
  always_comb begin
    tick_s       = (div_cnt_r == DIV_LAST);
    h_wrap_s     = tick_s && (h_r == H_LAST);
    frame_wrap_s = h_wrap_s && (v_r == V_LAST);
    if (tick_s) begin
      div_next_s = {DW{1'b0}};
    end else begin
      div_next_s = div_cnt_r + DW'(1);
    end
    if (!tick_s) begin
      h_next_s = h_r;
    end else if (h_wrap_s) begin
      h_next_s = 10'd0;
    end else begin
      h_next_s = h_r + 10'd1;
    end
    if (!h_wrap_s) begin
      v_next_s = v_r;
    end else if (v_r == V_LAST) begin
      v_next_s = 10'd0;
    end else begin
      v_next_s = v_r + 10'd1;
    end
  end

  // Counters and outputs; outputs decode the next (h, v) so they land with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r     <= {DW{1'b0}};
      p_tick_r      <= 1'b0;
      h_r           <= H_LAST;
      v_r           <= V_LAST;
      video_on_r    <= 1'b0;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      div_cnt_r     <= div_next_s;
      p_tick_r      <= (div_next_s == DIV_LAST);
      h_r           <= h_next_s;
      v_r           <= v_next_s;
      video_on_r    <= ({1'b0, h_next_s} < H_VIS) && ({1'b0, v_next_s} < V_VIS);
      hsync_r       <= !(({1'b0, h_next_s} >= HS_BEG) && ({1'b0, h_next_s} < HS_END));
      vsync_r       <= !(({1'b0, v_next_s} >= VS_BEG) && ({1'b0, v_next_s} < VS_END));
      frame_start_r <= frame_wrap_s;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_r;

  // Frame counter advances on the same edge that raises frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 8'd0;
    end else if (frame_wrap_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

  assign p_tick      = p_tick_r;
  assign pixel_x     = h_r;
  assign pixel_y     = v_r;
  assign video_on    = video_on_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign frame_start = frame_start_r;

endmodule
